// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: operation codes,
// controller states and the LO value written on a divide by zero.
package ex_muldiv_unit_pkg;

    // op[1] selects divide, op[0] selects signed arithmetic
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // LO after a divide by zero: all ones
    localparam logic [31:0] DZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One 64-bit accumulator holds the running product (multiply) or the
// remainder:quotient pair (restoring divide); a single adder/subtractor on
// the upper half performs one step per cycle. Sign handling is done by
// working on magnitudes and correcting in the FIX state.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] DZ_LO_W = {XLEN{DZ_LO[0]}};

    state_e            state_reg;
    state_e            state_next;
    logic [2*XLEN-1:0] acc_reg;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   opnd_reg;
    logic [CW-1:0]     cnt_reg;
    logic              is_div_reg;
    logic              neg_lo_reg;
    logic              neg_hi_reg;
    logic              dz_reg;
    logic [XLEN-1:0]   hi_reg;
    logic [XLEN-1:0]   lo_reg;
    logic              done_reg;

    logic              op_div;
    logic              op_signed;
    logic              b_zero;
    logic              start_ok;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN+1:0]   add_x;
    logic [XLEN+1:0]   add_y;
    logic [XLEN+1:0]   sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    assign op_div    = (op == OP_DIVU) || (op == OP_DIV);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign b_zero    = (b == '0);
    assign start_ok  = (state_reg == S_IDLE) && start;
    assign abs_a     = (op_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
    assign abs_b     = (op_signed && b[XLEN-1]) ? (~b + 1'b1) : b;

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a divide by zero skips the iteration entirely
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (op_div && b_zero) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_reg == CW'(ITER - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Shared adder: multiply adds the multiplicand to the upper half; divide
    // subtracts the divisor from the upper half shifted left by one, using a
    // two-bit headroom so the borrow lands in the top bit.
    always_comb begin
        add_x = '0;
        add_y = '0;
        if (is_div_reg) begin
            add_x = {1'b0, acc_reg[2*XLEN-1:XLEN-1]};
            add_y = ~{2'b00, opnd_reg};
        end else begin
            add_x = {2'b00, acc_reg[2*XLEN-1:XLEN]};
            add_y = {2'b00, opnd_reg};
        end
        sum = add_x + add_y + {{(XLEN+1){1'b0}}, is_div_reg};
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract
    // for divide (quotient bits shift in at the bottom of the accumulator)
    always_comb begin
        acc_step = acc_reg;
        if (is_div_reg) begin
            if (!sum[XLEN+1]) begin
                acc_step = {sum[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {acc_reg[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_reg[0]) begin
                acc_step = {sum[XLEN:0], acc_reg[XLEN-1:1]};
            end else begin
                acc_step = {1'b0, acc_reg[2*XLEN-1:1]};
            end
        end
    end

    // Sign correction applied on the way into HI/LO
    always_comb begin
        prod_fix = neg_lo_reg ? (~acc_reg + 1'b1) : acc_reg;
        fix_hi   = acc_reg[2*XLEN-1:XLEN];
        fix_lo   = acc_reg[XLEN-1:0];
        if (dz_reg) begin
            fix_hi = acc_reg[2*XLEN-1:XLEN];
            fix_lo = acc_reg[XLEN-1:0];
        end else if (!is_div_reg) begin
            fix_hi = prod_fix[2*XLEN-1:XLEN];
            fix_lo = prod_fix[XLEN-1:0];
        end else begin
            fix_lo = neg_lo_reg ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
            fix_hi = neg_hi_reg ? (~acc_reg[2*XLEN-1:XLEN] + 1'b1) : acc_reg[2*XLEN-1:XLEN];
        end
    end

    // Datapath, HI/LO and done pulse; MTHI/MTLO only land in IDLE without start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            opnd_reg   <= '0;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
            dz_reg     <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_ok) begin
                        is_div_reg <= op_div;
                        neg_lo_reg <= op_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_hi_reg <= op_signed && (op_div ? a[XLEN-1] : (a[XLEN-1] ^ b[XLEN-1]));
                        cnt_reg    <= '0;
                        opnd_reg   <= abs_b;
                        if (op_div && b_zero) begin
                            dz_reg  <= 1'b1;
                            acc_reg <= {a, DZ_LO_W};
                        end else begin
                            dz_reg  <= 1'b0;
                            acc_reg <= {{XLEN{1'b0}}, abs_a};
                        end
                    end else begin
                        if (hi_we) begin
                            hi_reg <= wdata;
                        end
                        if (lo_we) begin
                            lo_reg <= wdata;
                        end
                    end
                end
                S_RUN: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                S_FIX: begin
                    hi_reg   <= fix_hi;
                    lo_reg   <= fix_lo;
                    done_reg <= 1'b1;
                end
                default: begin
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, hazard and
// reset sequences, then randomized operations against an arithmetic model.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        logic [63:0] up;
        longint      sp;
        longint      sx;
        longint      sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        h = '0;
        l = '0;
        case (o)
            2'b00: begin
                up = {32'b0, x} * {32'b0, y};
                h = up[63:32];
                l = up[31:0];
            end
            2'b01: begin
                sp = sx * sy;
                up = 64'(sp);
                h = up[63:32];
                l = up[31:0];
            end
            2'b10: begin
                if (y == 0) begin
                    h = x;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
            default: begin
                if (y == 0) begin
                    h = x;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = 32'(sx / sy);
                    h = 32'(sx % sy);
                end
            end
        endcase
    endfunction

    // Issues one operation and checks the busy window, done timing and result.
    // disturb: assert hi_we and a second start mid-operation.
    // with_lo: assert lo_we together with start; LO must not take the write.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit disturb, input bit with_lo, input string nm);
        int          lat;
        logic [31:0] lo_before;
        bit          tl_ok;
        lat = (o[1] && y == 0) ? 1 : 33;
        lo_before = lo;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        if (with_lo) begin
            lo_we = 1'b1;
            wdata = 32'h0000_5555;
        end
        @(posedge clk);
        tl_ok = 1'b1;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                lo_we = 1'b0;
                a = $urandom;
                b = $urandom;
                op = 2'($urandom);
                if (with_lo) chk({nm, "_lo_discard"}, lo, lo_before);
            end
            if (!(busy === 1'b1 && done === 1'b0)) tl_ok = 1'b0;
            if (disturb && c == 5) begin
                start = 1'b1;
                hi_we = 1'b1;
                wdata = 32'h0000_1234;
                op = 2'b10;
                b = 32'h0;
            end
            if (disturb && c == 6) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
        end
        chk({nm, "_busy_window"}, 32'(tl_ok), 32'd1);
        @(negedge clk);
        chk({nm, "_done"}, {30'b0, busy, done}, 32'b01);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        @(negedge clk);
        chk({nm, "_done_drop"}, {30'b0, busy, done}, 32'b00);
    endtask

    vec_t vecs[6];

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5"};
        vecs[2] = '{2'b10, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, "divu_100_7"};
        vecs[3] = '{2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2"};
        vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"};
        vecs[5] = '{2'b10, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0"};

        rst_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, 30'b0}, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0, 1'b0, vecs[i].name);
            $display("vector %s hi=%08h lo=%08h", vecs[i].name, hi, lo);
        end

        // MTLO in IDLE, then MTHI+MTLO together
        lo_we = 1'b1;
        wdata = 32'h0000_AAAA;
        @(posedge clk);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_AAAA);
        chk("mtlo_hi_kept", hi, 32'h0000_1234);
        chk("mtlo_no_done", {31'b0, done}, 32'h0);
        $display("mtlo lo=%08h", lo);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mthilo_hi", hi, 32'h0BAD_F00D);
        chk("mthilo_lo", lo, 32'h0BAD_F00D);
        $display("mthi+mtlo hi=%08h lo=%08h", hi, lo);

        // MTHI and second start during a MULT are ignored
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0, "mult_disturbed");
        $display("disturbed mult hi=%08h lo=%08h", hi, lo);

        // MTLO together with start is discarded
        run_op(2'b10, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, 1'b1, "start_with_mtlo");
        $display("start+mtlo hi=%08h lo=%08h", hi, lo);

        // Asynchronous reset in cycle 10 of a MULT
        start = 1'b1;
        op = 2'b01;
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_state", {busy, done, 30'b0}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        $display("async reset busy=%0b hi=%08h lo=%08h", busy, hi, lo);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b10, 32'd9, 32'd3, 32'h0, 32'h3, 1'b0, 1'b0, "divu_after_reset");
        $display("divu 9/3 hi=%08h lo=%08h", hi, lo);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'h0;
                1: rb = $urandom_range(1, 15);
                2: rb = ~32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            if (i % 7 == 3) ra = 32'h8000_0000;
            model(ro, ra, rb, eh, el);
            run_op(ro, ra, rb, eh, el, 1'b0, 1'b0, "random");
            $display("random op=%0d a=%08h b=%08h hi=%08h lo=%08h", ro, ra, rb, hi, lo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
